seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 11 +
 rtl/div_step.sv | 18 +
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared defaults and FSM encoding for the sequential restoring divider.
package div_pkg;
    localparam int DEF_DIVIDEND_W = 7;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module div_step #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] rem_in,
    input  logic          dbit,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_out,
    output logic          qbit
);
    logic [DW:0] shifted;

    assign shifted = {rem_in, dbit};
    assign qbit    = (shifted >= {1'b0, divisor});
    // The kept remainder is below the divisor, so its top bit is always zero
    // except for a zero divisor, where dropping it yields dividend[DW-1:0].
    assign rem_out = qbit ? DW'(shifted - {1'b0, divisor}) : shifted[DW-1:0];
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready handshake.
// Define SEQ_DIVIDER_ZERO_CHECK_EN to short-circuit a zero divisor and flag div_by_zero.
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    localparam int CW = $clog2(DIVIDEND_W + 1);

    state_t                state;
    logic [DIVIDEND_W-1:0] work;      // unconsumed dividend bits, quotient bits fill from the LSB
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [DIVISOR_W-1:0]  rem;
    logic [CW-1:0]         count;
    logic [DIVISOR_W-1:0]  rem_next;
    logic                  qbit;
    logic                  dbz_q;

    div_step #(.DW(DIVISOR_W)) u_step (
        .rem_in  (rem),
        .dbit    (work[DIVIDEND_W-1]),
        .divisor (divisor_q),
        .rem_out (rem_next),
        .qbit    (qbit)
    );

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz_q     <= 1'b0;
            work      <= '0;
            divisor_q <= '0;
            rem       <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work      <= dividend;
                        divisor_q <= divisor;
                        rem       <= '0;
                        count     <= CW'(DIVIDEND_W);
                        in_ready  <= 1'b0;
                        state     <= CALC;
                    end
                end
                CALC: begin
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
                    if (divisor_q == '0) begin
                        quotient  <= '1;
                        remainder <= '0;
                        dbz_q     <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else
`endif
                    begin
                        work  <= {work[DIVIDEND_W-2:0], qbit};
                        rem   <= rem_next;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            quotient  <= {work[DIVIDEND_W-2:0], qbit};
                            remainder <= rem_next;
                            dbz_q     <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Release returns to IDLE only; operands are taken from the next edge on.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized traffic
// against an arithmetic reference model.
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, latency count, result check, DONE hold, release.
    task automatic run_op(input logic [6:0] a, input logic [3:0] b, input int hold);
        logic [6:0] eq;
        logic [3:0] er;
        logic       ed;
        int         el;
        int         lat;
        int         wait_cnt;

        if (b != 4'd0) begin
            eq = a / {3'b0, b};
            er = 4'(a % {3'b0, b});
            ed = 1'b0;
            el = 7;
        end else begin
            eq = 7'h7f;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            er = 4'd0;
            ed = 1'b1;
            el = 1;
`else
            er = a[3:0];
            ed = 1'b0;
            el = 7;
`endif
        end

        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);

        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = 7'($urandom);
        divisor  = 4'($urandom);
        check("in_ready_after_accept", {31'b0, in_ready}, 32'd0);

        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, el);
        check("quotient", {25'b0, quotient}, {25'b0, eq});
        check("remainder", {28'b0, remainder}, {28'b0, er});
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, ed});

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            dividend = 7'($urandom);
            divisor  = 4'($urandom);
            tick();
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_quotient", {25'b0, quotient}, {25'b0, eq});
            check("hold_remainder", {28'b0, remainder}, {28'b0, er});
        end

        // in_valid stays high across the release edge and must not be taken.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_out_valid", {31'b0, out_valid}, 32'd0);
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [6:0] ra;
        logic [3:0] rb;

        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_quotient", {25'b0, quotient}, 32'd0);
        check("reset_remainder", {28'b0, remainder}, 32'd0);
        check("reset_div_by_zero", {31'b0, div_by_zero}, 32'd0);

        run_op(7'd100, 4'd7, 0);
        run_op(7'd127, 4'd1, 0);
        run_op(7'd5, 4'd15, 1);
        run_op(7'd0, 4'd9, 0);
        run_op(7'd42, 4'd0, 0);
        run_op(7'd100, 4'd7, 5);

        // Reset lands on the third CALC edge of an in-flight operation.
        in_valid = 1'b1;
        dividend = 7'd100;
        divisor  = 4'd7;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("midcalc_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midcalc_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midcalc_rst_quotient", {25'b0, quotient}, 32'd0);
        check("midcalc_rst_remainder", {28'b0, remainder}, 32'd0);
        check("midcalc_rst_div_by_zero", {31'b0, div_by_zero}, 32'd0);
        run_op(7'd100, 4'd7, 0);

        for (int i = 0; i < 40; i++) begin
            ra = 7'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
